// File: rtl/sram_seq_pkg.sv
// Shared state encoding and Bennett phase assignments for the SRAM bank sequencer.
// The helper functions map each wait state to the phase edge it is waiting for.
package sram_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_ADDR,
        WAIT_DATA,
        WAIT_CTRL,
        WAIT_WEN,
        WAIT_END,
        WAIT_F9,
        WAIT_F6,
        WAIT_CAP,
        DONE
    } seq_state_e;

    localparam int PH_ADDR = 2;
    localparam int PH_DATA = 4;
    localparam int PH_CTRL = 6;
    localparam int PH_WEN  = 8;
    localparam int PH_END  = 9;
    localparam int PH_CAP  = 0;

    // Phase whose rise the state is waiting for; -1 when none.
    function automatic int awaited_rise(seq_state_e s);
        case (s)
            WAIT_ADDR: return PH_ADDR;
            WAIT_DATA: return PH_DATA;
            WAIT_CTRL: return PH_CTRL;
            WAIT_WEN:  return PH_WEN;
            WAIT_END:  return PH_END;
            default:   return -1;
        endcase
    endfunction

    // Phase whose fall the state is waiting for; -1 when none.
    function automatic int awaited_fall(seq_state_e s);
        case (s)
            WAIT_F9:  return PH_END;
            WAIT_F6:  return PH_CTRL;
            WAIT_CAP: return PH_CAP;
            default:  return -1;
        endcase
    endfunction

endpackage

// File: rtl/phase_edge_detect.sv
// Per-phase rise/fall detection of the Bennett phase vector against its registered copy.
// Edges are suppressed while reset is held so no stale edge is seen on release.
module phase_edge_detect #(
    parameter int NPH = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NPH-1:0] clkpos,
    output logic [NPH-1:0] rise,
    output logic [NPH-1:0] fall
);

    logic [NPH-1:0] ph_q;

    // Reset also loads the live vector so the first compare after reset is clean.
    always_ff @(posedge clk) begin
        ph_q <= clkpos;
    end

    for (genvar k = 0; k < NPH; k++) begin : g_ph
        assign rise[k] = ~reset &  clkpos[k] & ~ph_q[k];
        assign fall[k] = ~reset & ~clkpos[k] &  ph_q[k];
    end

endmodule

// File: rtl/sram_bank_sequencer.sv
// Steps one SRAM bank write or dual-port read through the Bennett phase schedule,
// driving address, data and control strobes on the awaited phase edges.
module sram_bank_sequencer
    import sram_seq_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int NPH    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPH-1:0]    clkpos,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] Addr_A,
    output logic [ADDR_W-1:0] Addr_B,
    output logic [DATA_W-1:0] in,
    output logic              ReadEn,
    output logic              WriteEn,
    output logic              RegWrtBar,
    input  logic [DATA_W-1:0] outA,
    input  logic [DATA_W-1:0] outB,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata_a,
    output logic [DATA_W-1:0] rsp_rdata_b,
    output logic              seq_err
);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr_a;
        logic [ADDR_W-1:0] addr_b;
        logic [DATA_W-1:0] wdata;
    } req_t;

    logic [NPH-1:0] rise, fall;

    phase_edge_detect #(.NPH(NPH)) u_edge (
        .clk    (clk),
        .reset  (reset),
        .clkpos (clkpos),
        .rise   (rise),
        .fall   (fall)
    );

    seq_state_e        state_q, state_d;
    req_t              req_q, req_d;
    logic [ADDR_W-1:0] addr_a_d, addr_b_d;
    logic [DATA_W-1:0] in_d, rdata_a_d, rdata_b_d;
    logic              ren_d, wen_d, rwb_d, rsp_valid_d, seq_err_d, req_ready_d;
    logic              rhit, fhit, late;
    int                rph, fph;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_a_d    = Addr_A;
        addr_b_d    = Addr_B;
        in_d        = in;
        ren_d       = ReadEn;
        wen_d       = WriteEn;
        rwb_d       = RegWrtBar;
        rdata_a_d   = rsp_rdata_a;
        rdata_b_d   = rsp_rdata_b;
        rsp_valid_d = 1'b0;
        seq_err_d   = 1'b0;

        // Only the edge the current state awaits is acted on; a later rise is an order fault.
        rph  = awaited_rise(state_q);
        fph  = awaited_fall(state_q);
        rhit = 1'b0;
        fhit = 1'b0;
        late = 1'b0;
        for (int k = 0; k < NPH; k++) begin
            if (k == rph && rise[k]) rhit = 1'b1;
            if (k == fph && fall[k]) fhit = 1'b1;
            if (rph >= 0 && k > rph && rise[k]) late = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    req_d   = '{write: req_write, addr_a: req_addr_a,
                                addr_b: req_addr_b, wdata: req_wdata};
                    state_d = WAIT_ADDR;
                end
            end
            WAIT_ADDR: begin
                if (rhit) begin
                    addr_a_d = req_q.addr_a;
                    addr_b_d = req_q.addr_b;
                    state_d  = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (rhit) begin
                    in_d    = req_q.write ? req_q.wdata : '0;
                    state_d = WAIT_CTRL;
                end
            end
            WAIT_CTRL: begin
                if (rhit) begin
                    if (req_q.write) rwb_d = 1'b1;
                    else             ren_d = 1'b1;
                    state_d = WAIT_WEN;
                end
            end
            WAIT_WEN: begin
                if (rhit) begin
                    if (req_q.write) wen_d = 1'b1;
                    else             ren_d = 1'b0;
                    state_d = WAIT_END;
                end
            end
            WAIT_END: begin
                if (rhit) begin
                    if (req_q.write) begin
                        wen_d   = 1'b0;
                        state_d = WAIT_F9;
                    end else begin
                        state_d = WAIT_CAP;
                    end
                end
            end
            WAIT_F9: begin
                if (fhit) state_d = WAIT_F6;
            end
            WAIT_F6: begin
                if (fhit) begin
                    rwb_d   = 1'b0;
                    state_d = DONE;
                end
            end
            WAIT_CAP: begin
                if (fhit) begin
                    rdata_a_d = outA;
                    rdata_b_d = outB;
                    state_d   = DONE;
                end
            end
            DONE: begin
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A request still parked in WAIT_ADDR legitimately sees later rises of the current cycle.
        if (state_q != WAIT_ADDR && late && !rhit) begin
            seq_err_d = 1'b1;
            ren_d     = 1'b0;
            wen_d     = 1'b0;
            rwb_d     = 1'b0;
            state_d   = IDLE;
        end

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            req_ready   <= 1'b0;
            Addr_A      <= '0;
            Addr_B      <= '0;
            in          <= '0;
            ReadEn      <= 1'b0;
            WriteEn     <= 1'b0;
            RegWrtBar   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata_a <= '0;
            rsp_rdata_b <= '0;
            seq_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            req_ready   <= req_ready_d;
            Addr_A      <= addr_a_d;
            Addr_B      <= addr_b_d;
            in          <= in_d;
            ReadEn      <= ren_d;
            WriteEn     <= wen_d;
            RegWrtBar   <= rwb_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata_a <= rdata_a_d;
            rsp_rdata_b <= rdata_b_d;
            seq_err     <= seq_err_d;
        end
    end

endmodule

// File: tb/tb_sram_bank_sequencer.sv
// Directed bench: drives the Bennett phase vector one edge per clk against a small bank model.
// Each step changes clkpos on a falling clk edge and samples outputs on the next falling edge.
module tb_sram_bank_sequencer;

    localparam int AW  = 5;
    localparam int DW  = 16;
    localparam int NPH = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [NPH-1:0] clkpos;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr_a, req_addr_b, Addr_A, Addr_B;
    logic [DW-1:0] req_wdata, din, outA, outB, rsp_rdata_a, rsp_rdata_b;
    logic          ReadEn, WriteEn, RegWrtBar, rsp_valid, seq_err;

    always #5 clk = ~clk;

    sram_bank_sequencer #(.ADDR_W(AW), .DATA_W(DW), .NPH(NPH)) dut (
        .clk         (clk),
        .reset       (reset),
        .clkpos      (clkpos),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr_a  (req_addr_a),
        .req_addr_b  (req_addr_b),
        .req_wdata   (req_wdata),
        .Addr_A      (Addr_A),
        .Addr_B      (Addr_B),
        .in          (din),
        .ReadEn      (ReadEn),
        .WriteEn     (WriteEn),
        .RegWrtBar   (RegWrtBar),
        .outA        (outA),
        .outB        (outB),
        .rsp_valid   (rsp_valid),
        .rsp_rdata_a (rsp_rdata_a),
        .rsp_rdata_b (rsp_rdata_b),
        .seq_err     (seq_err)
    );

    // Bank model: row i preset to 16'h1000+i, written while WriteEn is high.
    logic [DW-1:0] mem [2**AW];
    logic          mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= 16'h1000 + 16'(i);
        end else if (WriteEn) begin
            mem[Addr_A] <= din;
        end
    end
    assign outA = mem[Addr_A];
    assign outB = mem[Addr_B];

    int checks = 0, errors = 0, rsp_cnt = 0, err_cnt = 0;

    always @(posedge clk) begin
        if (rsp_valid === 1'b1) rsp_cnt++;
        if (seq_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic step_rise(input int k);
        clkpos[k] = 1'b1;
        @(negedge clk);
    endtask

    task automatic step_fall(input int k);
        clkpos[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic rises(input int a, input int b);
        for (int k = a; k <= b; k++) step_rise(k);
    endtask

    task automatic falls(input int a, input int b);
        for (int k = a; k >= b; k--) step_fall(k);
    endtask

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [DW-1:0] d);
        req_valid = 1'b1; req_write = w; req_addr_a = a; req_addr_b = b; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_init = 1'b1; clkpos = '0;
        req_valid = 1'b0; req_write = 1'b0; req_addr_a = '0; req_addr_b = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_ctrl", {ReadEn, WriteEn, RegWrtBar, rsp_valid, seq_err}, 0);
        chk("rst_addr_in", {Addr_A, Addr_B, din}, 0);
        reset = 1'b0; mem_init = 1'b0;
        tick();
        chk("idle_ready", req_ready, 1);

        // Write row 4 with AAAA
        send(1'b1, 5'd4, 5'd4, 16'hAAAA);
        chk("wr_accept", req_ready, 0);
        rises(0, 1);
        chk("wr_addr_hold", {Addr_A, Addr_B}, 0);
        step_rise(2);
        chk("wr_addr", {Addr_A, Addr_B}, {5'd4, 5'd4});
        rises(3, 4);
        chk("wr_in", din, 16'hAAAA);
        rises(5, 6);
        chk("wr_rwb_on", {ReadEn, WriteEn, RegWrtBar}, 3'b001);
        rises(7, 8);
        chk("wr_wen_on", {ReadEn, WriteEn, RegWrtBar}, 3'b011);
        step_rise(9);
        chk("wr_wen_off", {ReadEn, WriteEn, RegWrtBar}, 3'b001);
        falls(9, 7);
        chk("wr_rwb_hold", {ReadEn, WriteEn, RegWrtBar}, 3'b001);
        step_fall(6);
        chk("wr_rwb_off", {ReadEn, WriteEn, RegWrtBar}, 3'b000);
        chk("wr_rsp_early", rsp_valid, 0);
        step_fall(5);
        chk("wr_rsp", {rsp_valid, req_ready}, 2'b11);
        step_fall(4);
        chk("wr_rsp_pulse", rsp_valid, 0);
        falls(3, 0);
        chk("wr_mem4", mem[4], 16'hAAAA);
        chk("wr_rsp_cnt", rsp_cnt, 1);

        // Dual-port read rows 1 and 4
        send(1'b0, 5'd1, 5'd4, 16'hFFFF);
        rises(0, 2);
        chk("rd_addr", {Addr_A, Addr_B}, {5'd1, 5'd4});
        rises(3, 4);
        chk("rd_in_zero", din, 0);
        rises(5, 6);
        chk("rd_ren_on", {ReadEn, WriteEn, RegWrtBar}, 3'b100);
        rises(7, 8);
        chk("rd_ren_off", {ReadEn, WriteEn, RegWrtBar}, 3'b000);
        step_rise(9);
        falls(9, 1);
        chk("rd_no_capture_yet", rsp_rdata_b, 0);
        step_fall(0);
        chk("rd_data_a", rsp_rdata_a, 16'h1001);
        chk("rd_data_b", rsp_rdata_b, 16'hAAAA);
        tick();
        chk("rd_rsp", rsp_valid, 1);
        tick();
        chk("rd_rsp_cnt", rsp_cnt, 2);
        chk("rd_data_held", rsp_rdata_b, 16'hAAAA);

        // Request accepted after rise[4] waits for next cycle's rise[2]
        rises(0, 4);
        send(1'b1, 5'd7, 5'd7, 16'h5555);
        chk("late_accept", req_ready, 0);
        rises(5, 6);
        chk("late_ctrl6", {ReadEn, WriteEn, RegWrtBar}, 0);
        rises(7, 9);
        chk("late_ctrl9", {ReadEn, WriteEn, RegWrtBar}, 0);
        falls(9, 0);
        rises(0, 1);
        chk("late_addr_hold", {Addr_A, Addr_B}, {5'd1, 5'd4});
        chk("late_in_hold", din, 0);
        chk("late_no_err", err_cnt, 0);
        step_rise(2);
        chk("late_addr", {Addr_A, Addr_B}, {5'd7, 5'd7});
        rises(3, 9);
        falls(9, 0);
        chk("late_mem7", mem[7], 16'h5555);
        chk("late_rsp_cnt", rsp_cnt, 3);

        // Reset during WAIT_WEN of a write
        send(1'b1, 5'd9, 5'd9, 16'h1234);
        rises(0, 6);
        chk("mid_pre", {ReadEn, WriteEn, RegWrtBar}, 3'b001);
        reset = 1'b1;
        tick();
        chk("mid_ctrl", {ReadEn, WriteEn, RegWrtBar, rsp_valid}, 0);
        chk("mid_ready", req_ready, 0);
        reset = 1'b0;
        tick();
        chk("mid_idle", req_ready, 1);
        rises(7, 9);
        falls(9, 0);
        chk("mid_mem9", mem[9], 16'h1009);
        chk("mid_rsp_cnt", rsp_cnt, 3);

        // Out-of-order rise[6] while waiting for rise[4]
        send(1'b0, 5'd2, 5'd3, 16'h0);
        rises(0, 2);
        chk("se1_addr", {Addr_A, Addr_B}, {5'd2, 5'd3});
        step_rise(6);
        chk("se1_err", seq_err, 1);
        chk("se1_ctrl", {ReadEn, WriteEn, RegWrtBar}, 0);
        chk("se1_ready", req_ready, 1);
        step_rise(3);
        chk("se1_pulse", seq_err, 0);
        rises(4, 5);
        rises(7, 9);
        falls(9, 0);

        // Out-of-order rise[9] while ReadEn is high and rise[8] is awaited
        send(1'b0, 5'd5, 5'd6, 16'h0);
        rises(0, 6);
        chk("se2_pre", {ReadEn, WriteEn, RegWrtBar}, 3'b100);
        step_rise(9);
        chk("se2_err", seq_err, 1);
        chk("se2_ctrl", {ReadEn, WriteEn, RegWrtBar}, 0);
        rises(7, 8);
        falls(9, 0);
        chk("se_err_cnt", err_cnt, 2);
        chk("se_rsp_cnt", rsp_cnt, 3);

        // Back-to-back write then read with req_valid held
        req_valid = 1'b1; req_write = 1'b1; req_addr_a = 5'd3; req_addr_b = 5'd3;
        req_wdata = 16'h0F0F;
        tick();
        chk("b2b_acc0", req_ready, 0);
        req_write = 1'b0; req_addr_a = 5'd3; req_addr_b = 5'd4; req_wdata = '0;
        rises(0, 9);
        falls(9, 6);
        step_fall(5);
        chk("b2b_rsp0", {rsp_valid, req_ready}, 2'b11);
        step_fall(4);
        chk("b2b_acc1", {rsp_valid, req_ready}, 2'b00);
        req_valid = 1'b0;
        falls(3, 0);
        rises(0, 1);
        chk("b2b_addr_hold", {Addr_A, Addr_B}, {5'd3, 5'd3});
        step_rise(2);
        chk("b2b_addr", {Addr_A, Addr_B}, {5'd3, 5'd4});
        rises(3, 9);
        falls(9, 0);
        chk("b2b_data_a", rsp_rdata_a, 16'h0F0F);
        chk("b2b_data_b", rsp_rdata_b, 16'hAAAA);
        tick();
        chk("b2b_rsp1", rsp_valid, 1);
        tick();
        chk("b2b_rsp_cnt", rsp_cnt, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
